// File: rtl/latch_sync_filter.sv
// Synchronizes an asynchronous level (e.g. a latch primitive's Q) and qualifies it over
// FILT_CNT consecutive enabled cycles. Optional CLR/STICKY: define LATCH_SYNC_FILTER_STICKY_EN.
module latch_sync_filter #(
  parameter logic INIT        = 1'b1,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CNT    = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CE,
  input  logic D,
  output logic Q,
  output logic RISE,
  output logic FALL,
  output logic BUSY
`ifdef LATCH_SYNC_FILTER_STICKY_EN
  ,
  input  logic CLR,
  output logic STICKY
`endif
);

  localparam int             CW       = $clog2(FILT_CNT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILT_CNT - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  typedef enum logic {
    STABLE = 1'b0,
    COUNT  = 1'b1
  } state_t;

  // Declaration initializers give power-up values equal to the reset values.
  state_t                 state = STABLE;
  state_t                 state_n;
  logic [CW-1:0]          cnt = '0;
  logic [CW-1:0]          cnt_n;
  logic [SYNC_STAGES-1:0] sync = {SYNC_STAGES{INIT}};
  logic                   q_r = INIT;
  logic                   rise_r = 1'b0;
  logic                   fall_r = 1'b0;
  logic                   q_n;
  logic                   rise_n;
  logic                   fall_n;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // Handshake-free block: CE is a plain enable; a low CE freezes all qualification state.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    q_n     = q_r;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    if (CE) begin
      case (state)
        STABLE: begin
          if (s != q_r) begin
            if (FILT_CNT == 1) begin
              q_n    = s;
              rise_n = s;
              fall_n = ~s;
            end else begin
              state_n = COUNT;
              cnt_n   = CNT_ONE;
            end
          end
        end
        COUNT: begin
          if (s == q_r) begin
            state_n = STABLE;
            cnt_n   = '0;
          end else if (cnt == CNT_LAST) begin
            q_n     = s;
            rise_n  = s;
            fall_n  = ~s;
            cnt_n   = '0;
            state_n = STABLE;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        default: begin
          state_n = STABLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync   <= {SYNC_STAGES{INIT}};
      state  <= STABLE;
      cnt    <= '0;
      q_r    <= INIT;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      if (CE) sync <= {sync[SYNC_STAGES-2:0], D};
      state  <= state_n;
      cnt    <= cnt_n;
      q_r    <= q_n;
      rise_r <= rise_n;
      fall_r <= fall_n;
    end
  end

  assign Q    = q_r;
  assign RISE = rise_r;
  assign FALL = fall_r;
  assign BUSY = (state == COUNT);

`ifdef LATCH_SYNC_FILTER_STICKY_EN
  logic sticky_r = 1'b0;

  // A new edge pulse beats a simultaneous clear so no event is ever lost.
  always_ff @(posedge CLK) begin
    if (RESET)                 sticky_r <= 1'b0;
    else if (rise_n || fall_n) sticky_r <= 1'b1;
    else if (CLR)              sticky_r <= 1'b0;
  end

  assign STICKY = sticky_r;
`else
  // No event-capture flag in this build.
`endif

endmodule

// File: tb/tb_latch_sync_filter.sv
// Bench for latch_sync_filter: three parameterizations driven by shared stimulus and
// checked every cycle against a run-length reference model.
module tb_latch_sync_filter;

  localparam int   NI          = 3;
  localparam int   SS [NI]     = '{2, 2, 3};
  localparam int   FC [NI]     = '{4, 1, 5};
  localparam logic IV [NI]     = '{1'b1, 1'b1, 1'b0};

  logic CLK = 1'b0, RESET = 1'b0, CE = 1'b0, D = 1'b1, CLR = 1'b0;
  logic [NI-1:0] q, rise, fall, busy, sticky;

  int checks = 0;
  int errors = 0;

  // Reference model: delay line of sampled D, and run length of edges where S differs from Q.
  logic [3:0] m_pipe [NI];
  logic       m_q    [NI];
  int         m_run  [NI];
  logic       m_rise [NI];
  logic       m_fall [NI];
  logic       m_stk  [NI];

  always #5 CLK = ~CLK;

`ifdef LATCH_SYNC_FILTER_STICKY_EN
  latch_sync_filter #(.INIT(1'b1), .SYNC_STAGES(2), .FILT_CNT(4)) dut_a (
    .CLK(CLK), .RESET(RESET), .CE(CE), .D(D), .Q(q[0]), .RISE(rise[0]), .FALL(fall[0]),
    .BUSY(busy[0]), .CLR(CLR), .STICKY(sticky[0]));
  latch_sync_filter #(.INIT(1'b1), .SYNC_STAGES(2), .FILT_CNT(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .CE(CE), .D(D), .Q(q[1]), .RISE(rise[1]), .FALL(fall[1]),
    .BUSY(busy[1]), .CLR(CLR), .STICKY(sticky[1]));
  latch_sync_filter #(.INIT(1'b0), .SYNC_STAGES(3), .FILT_CNT(5)) dut_c (
    .CLK(CLK), .RESET(RESET), .CE(CE), .D(D), .Q(q[2]), .RISE(rise[2]), .FALL(fall[2]),
    .BUSY(busy[2]), .CLR(CLR), .STICKY(sticky[2]));
`else
  assign sticky = '0;
  latch_sync_filter #(.INIT(1'b1), .SYNC_STAGES(2), .FILT_CNT(4)) dut_a (
    .CLK(CLK), .RESET(RESET), .CE(CE), .D(D), .Q(q[0]), .RISE(rise[0]), .FALL(fall[0]),
    .BUSY(busy[0]));
  latch_sync_filter #(.INIT(1'b1), .SYNC_STAGES(2), .FILT_CNT(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .CE(CE), .D(D), .Q(q[1]), .RISE(rise[1]), .FALL(fall[1]),
    .BUSY(busy[1]));
  latch_sync_filter #(.INIT(1'b0), .SYNC_STAGES(3), .FILT_CNT(5)) dut_c (
    .CLK(CLK), .RESET(RESET), .CE(CE), .D(D), .Q(q[2]), .RISE(rise[2]), .FALL(fall[2]),
    .BUSY(busy[2]));
`endif

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_pipe[i] = {4{IV[i]}};
      m_q[i]    = IV[i];
      m_run[i]  = 0;
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      m_stk[i]  = 1'b0;
    end
  endtask

  task automatic model_edge(input logic rst, input logic ce, input logic d, input logic clr);
    logic s;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NI; i++) begin
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      if (ce) begin
        s = m_pipe[i][SS[i]-1];
        if (s != m_q[i]) begin
          m_run[i]++;
          if (m_run[i] == FC[i]) begin
            m_rise[i] = s;
            m_fall[i] = ~s;
            m_q[i]    = s;
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        m_pipe[i] = {m_pipe[i][2:0], d};
      end
      if (m_rise[i] || m_fall[i]) m_stk[i] = 1'b1;
      else if (clr)               m_stk[i] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("q%0d", i), q[i], m_q[i]);
      chk($sformatf("rise%0d", i), rise[i], m_rise[i]);
      chk($sformatf("fall%0d", i), fall[i], m_fall[i]);
      chk($sformatf("busy%0d", i), busy[i], (m_run[i] != 0));
      chk($sformatf("excl%0d", i), rise[i] & fall[i], 1'b0);
`ifdef LATCH_SYNC_FILTER_STICKY_EN
      chk($sformatf("sticky%0d", i), sticky[i], m_stk[i]);
`endif
    end
  endtask

  task automatic step(input logic rst, input logic ce, input logic d, input logic clr);
    RESET = rst;
    CE    = ce;
    D     = d;
    CLR   = clr;
    model_edge(rst, ce, d, clr);
    @(posedge CLK);
    #1;
    check_all();
  endtask

  initial begin
    int found [NI];
    int n_en;
    int hold;
    logic rd;

    model_reset();
    #1;
    check_all();

    step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 1, 0);

    // D 1->0 held: a falls after SS+FC edges, b after SS+1; CLR collides with a's FALL.
    found = '{0, 0, 0};
    for (int n = 1; n <= 10; n++) begin
      step(0, 1, 0, n == 6);
      for (int i = 0; i < 2; i++) if (fall[i] && found[i] == 0) found[i] = n;
    end
    chk_int("fall_edge_a", found[0], 6);
    chk_int("fall_edge_b", found[1], 3);
    step(0, 1, 0, 1);

    // D 0->1 held: all three rise after SS+FC edges.
    found = '{0, 0, 0};
    for (int n = 1; n <= 12; n++) begin
      step(0, 1, 1, 0);
      for (int i = 0; i < NI; i++) if (rise[i] && found[i] == 0) found[i] = n;
    end
    for (int i = 0; i < NI; i++) chk_int($sformatf("rise_edge%0d", i), found[i], SS[i] + FC[i]);

    // Two-cycle glitch low: a must not fall.
    found = '{0, 0, 0};
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int n = 0; n < 8; n++) begin
      step(0, 1, 1, 0);
      if (fall[0]) found[0]++;
    end
    chk_int("glitch_falls_a", found[0], 0);

    // CE low for five cycles mid-qualification; only enabled edges count.
    n_en = 0;
    found[0] = 0;
    for (int n = 0; n < 3; n++) begin
      step(0, 1, 0, 0);
      n_en++;
    end
    for (int n = 0; n < 5; n++) step(0, 0, 0, 0);
    for (int n = 0; n < 8; n++) begin
      step(0, 1, 0, 0);
      n_en++;
      if (fall[0] && found[0] == 0) found[0] = n_en;
    end
    chk_int("ce_gap_fall_edge_a", found[0], 6);

    // Reset aborts qualification.
    for (int n = 0; n < 8; n++) step(0, 1, 1, 0);
    for (int n = 0; n < 4; n++) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int n = 0; n < 3; n++) step(0, 1, 0, 0);

    // Randomized runs of held levels with random CE, CLR and occasional reset.
    rd = 1'b1;
    for (int r = 0; r < 120; r++) begin
      rd   = $urandom_range(0, 1);
      hold = $urandom_range(1, 9);
      for (int k = 0; k < hold; k++)
        step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8, rd, $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/latch_sync_filter.md
LATCH_SYNC_FILTER -- requirements
Module: latch_sync_filter

Interface
REQ-001 SHALL have parameter INIT, default 1'b1, giving the reset/initial value of the synchronizer stages and Q.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth; legal range 2..4.
REQ-003 SHALL have parameter FILT_CNT, default 4, giving the consecutive-cycle qualification count; legal range 1..255.
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port CE, input, 1 bit: clock enable for all non-reset state updates.
REQ-007 SHALL have port D, input, 1 bit: asynchronous level, typically the Q of an upstream latch primitive.
REQ-008 SHALL have port Q, output, 1 bit: filtered, synchronized level.
REQ-009 SHALL have port RISE, output, 1 bit: one-cycle pulse on a qualified 0->1 change of Q.
REQ-010 SHALL have port FALL, output, 1 bit: one-cycle pulse on a qualified 1->0 change of Q.
REQ-011 SHALL have port BUSY, output, 1 bit: high while in state COUNT.

Function
REQ-012 SHALL shift D through a SYNC_STAGES-deep flop chain on each CE-enabled edge; the last stage is S.
REQ-013 SHALL implement two states, STABLE and COUNT, plus a counter of width ceil(log2(FILT_CNT+1)).
REQ-014 STABLE: on S != Q, go to COUNT with cnt = 1; if FILT_CNT = 1, instead update Q <= S and stay in STABLE.
REQ-015 COUNT: on S == Q (glitch), go to STABLE with cnt = 0 and Q unchanged.
REQ-016 COUNT: on S != Q with cnt == FILT_CNT-1, set Q <= S, cnt <= 0, and go to STABLE.
REQ-017 COUNT: on S != Q otherwise, increment cnt.
REQ-018 Latency: a D level held stable SHALL reach Q exactly SYNC_STAGES + FILT_CNT CE-enabled edges after the first edge that samples it.
REQ-019 RISE/FALL SHALL be registered, asserted for exactly one CLK cycle, on the same edge that Q changes.
REQ-020 RISE and FALL SHALL never be high simultaneously.
REQ-021 With CE low, all state, Q and cnt SHALL hold, and RISE/FALL SHALL be driven 0 at that edge.
REQ-022 The counter SHALL never exceed FILT_CNT-1 and SHALL never wrap.
REQ-023 At simulation start (before any reset), all state SHALL initialize to the reset values, matching primitive-model initial-block behaviour.

Reset
REQ-024 RESET SHALL take priority over CE and all other inputs.
REQ-025 Reset values: sync stages = INIT, Q = INIT, state = STABLE, cnt = 0, RISE = FALL = BUSY = 0.
REQ-026 Reset asserted mid-COUNT SHALL abort qualification, with no RISE/FALL pulse at or after that edge.

Configuration
REQ-027 With macro LATCH_SYNC_FILTER_STICKY_EN defined, the block SHALL add input CLR (1 bit) and output STICKY (1 bit).
REQ-028 STICKY SHALL set on any RISE or FALL and clear on CLR; if both occur on the same edge, set SHALL win; reset value is 0; STICKY is not gated by CE.
REQ-029 Without LATCH_SYNC_FILTER_STICKY_EN, the CLR/STICKY ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 Reset with INIT=1, SYNC_STAGES=2, FILT_CNT=4 -> Q=1, BUSY=0, RISE=FALL=0 on the first post-reset cycle.
REQ-031 CE=1, D 1->0 held -> Q falls on edge 6 after the D change; FALL is high for that one cycle only; BUSY is high on edges 3..5.
REQ-032 D low for 2 cycles, then back high (FILT_CNT=4) -> Q stays 1; BUSY pulses; no FALL.
REQ-033 FILT_CNT=1, D 0->1 -> Q rises at edge 3; RISE for one cycle; BUSY never asserts.
REQ-034 CE low for 5 cycles mid-COUNT -> cnt and BUSY hold; qualification completes after CE returns, with the edge count excluding disabled cycles.
REQ-035 STICKY build: FALL and CLR on the same edge -> STICKY=1; CLR on the next edge -> STICKY=0; RESET mid-COUNT -> no pulse, STICKY=0.
